// File: rtl/qr_cordic_pkg.sv
// Shared constants and types for the QR_CORDIC Givens-rotation scheduler.
package qr_cordic_pkg;

  localparam int DEF_ROWS    = 8;
  localparam int DEF_COLS    = 4;
  localparam int DEF_MAX_OUT = 4;
  localparam int ENTRY_W     = 13;

  localparam logic MODE_VEC = 1'b0;
  localparam logic MODE_ROT = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VEC,
    ST_WAIT_VEC,
    ST_ROT,
    ST_DRAIN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/qr_credit_cnt.sv
// Outstanding-command counter: +1 per issued command, -1 per PE ack.
// An ack with nothing outstanding leaves the count alone and raises underflow.
module qr_credit_cnt #(
  parameter int MAX_OUT = 4,
  parameter int CNT_W   = $clog2(MAX_OUT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] cnt_nxt,
  output logic             underflow
);

  logic dec_ok;

  always_comb begin
    underflow = dec && (cnt == '0);
    dec_ok    = dec && !underflow;
    cnt_nxt   = cnt;
    if (inc && !dec_ok) begin
      cnt_nxt = cnt + CNT_W'(1);
    end else if (!inc && dec_ok) begin
      cnt_nxt = cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/qr_givens_sched.sv
// Sequences vectoring/rotation commands for a column-by-column, bottom-up Givens QR,
// draining the PE between row pairs and capping unacknowledged commands at MAX_OUT.
module qr_givens_sched
  import qr_cordic_pkg::*;
#(
  parameter int ROWS    = DEF_ROWS,
  parameter int COLS    = DEF_COLS,
  parameter int ROW_W   = 3,
  parameter int COL_W   = 2,
  parameter int MAX_OUT = DEF_MAX_OUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic             cmd_mode,
  output logic [ROW_W-1:0] cmd_row_hi,
  output logic [ROW_W-1:0] cmd_row_lo,
  output logic [COL_W-1:0] cmd_col,
  output logic             cmd_last,
  input  logic             pe_ack
);

  localparam int CNT_W = $clog2(MAX_OUT + 1);
  localparam logic [ROW_W-1:0] ROW_TOP = ROW_W'(ROWS - 1);
  localparam logic [ROW_W-1:0] ROW_ONE = ROW_W'(1);
  localparam logic [ROW_W-1:0] ROW_TWO = ROW_W'(2);
  localparam logic [COL_W-1:0] COL_END = COL_W'(COLS - 1);
  localparam logic [COL_W-1:0] COL_ONE = COL_W'(1);

  state_t           state;
  logic [ROW_W-1:0] i_q;
  logic [COL_W-1:0] j_q;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] outstanding_nxt;
  logic             underflow;
  logic             xfer;
  logic             can_issue;

  assign xfer      = cmd_valid && cmd_ready;
  // Credit is judged on the post-edge count so a registered valid never overshoots.
  assign can_issue = outstanding_nxt < CNT_W'(MAX_OUT);

  qr_credit_cnt #(
    .MAX_OUT (MAX_OUT),
    .CNT_W   (CNT_W)
  ) u_credit (
    .clk       (clk),
    .rst       (rst),
    .inc       (xfer),
    .dec       (pe_ack),
    .cnt       (outstanding),
    .cnt_nxt   (outstanding_nxt),
    .underflow (underflow)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      cmd_valid  <= 1'b0;
      cmd_mode   <= MODE_VEC;
      cmd_row_hi <= '0;
      cmd_row_lo <= '0;
      cmd_col    <= '0;
      cmd_last   <= 1'b0;
      i_q        <= '0;
      j_q        <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            j_q        <= '0;
            i_q        <= ROW_TOP;
            busy       <= 1'b1;
            state      <= ST_VEC;
            cmd_valid  <= 1'b1;
            cmd_mode   <= MODE_VEC;
            cmd_row_hi <= ROW_TOP - ROW_ONE;
            cmd_row_lo <= ROW_TOP;
            cmd_col    <= '0;
            cmd_last   <= (COL_END == '0);
          end
        end
        ST_VEC: begin
          if (xfer) begin
            cmd_valid <= 1'b0;
            state     <= ST_WAIT_VEC;
          end
        end
        ST_WAIT_VEC: begin
          // The angle exists only once the vectoring op has been acknowledged.
          if (outstanding == '0) begin
            if (j_q != COL_END) begin
              state     <= ST_ROT;
              cmd_valid <= 1'b1;
              cmd_mode  <= MODE_ROT;
              cmd_col   <= j_q + COL_ONE;
              cmd_last  <= ((j_q + COL_ONE) == COL_END);
            end else begin
              state <= ST_DRAIN;
            end
          end
        end
        ST_ROT: begin
          if (xfer) begin
            if (cmd_last) begin
              cmd_valid <= 1'b0;
              state     <= ST_DRAIN;
            end else begin
              cmd_col   <= cmd_col + COL_ONE;
              cmd_last  <= ((cmd_col + COL_ONE) == COL_END);
              cmd_valid <= can_issue;
            end
          end else if (!cmd_valid) begin
            cmd_valid <= can_issue;
          end
        end
        ST_DRAIN: begin
          if (outstanding == '0) begin
            if (i_q > (ROW_W'(j_q) + ROW_ONE)) begin
              i_q        <= i_q - ROW_ONE;
              state      <= ST_VEC;
              cmd_valid  <= 1'b1;
              cmd_mode   <= MODE_VEC;
              cmd_row_hi <= i_q - ROW_TWO;
              cmd_row_lo <= i_q - ROW_ONE;
              cmd_col    <= j_q;
              cmd_last   <= (j_q == COL_END);
            end else if (j_q == COL_END) begin
              state <= ST_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              j_q        <= j_q + COL_ONE;
              i_q        <= ROW_TOP;
              state      <= ST_VEC;
              cmd_valid  <= 1'b1;
              cmd_mode   <= MODE_VEC;
              cmd_row_hi <= ROW_TOP - ROW_ONE;
              cmd_row_lo <= ROW_TOP;
              cmd_col    <= j_q + COL_ONE;
              cmd_last   <= ((j_q + COL_ONE) == COL_END);
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
      if (underflow) begin
        err <= 1'b1;
      end else if (state == ST_IDLE && start) begin
        err <= 1'b0;
      end
    end
  end

endmodule

// File: doc/qr_givens_sched.md
Name: qr_givens_sched

Overview:
- Command scheduler that sequences Givens-rotation work on the QR_CORDIC datapath for a ROWS x COLS matrix (default 8x4, 13-bit entries held elsewhere).
- For each column j, it annihilates rows bottom-up using adjacent row pairs (i-1, i):
  - one vectoring op on column j,
  - then rotation ops on columns j+1..COLS-1 that reuse that angle.
- Sits between the top-level load/unload control (start/done) and the CORDIC processing element command port.
- Enforces the data dependency that each pair drains before the next pair touches a shared row.

Parameters:
- ROWS, 8, matrix row count (>= COLS+1)
- COLS, 4, matrix column count
- ROW_W, 3, row index width, clog2(ROWS)
- COL_W, 2, column index width, clog2(COLS)
- MAX_OUT, 4, maximum commands issued but not yet acknowledged by the PE

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  pulse; begins a decomposition when idle
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse when the last command is acknowledged
- err  out  1  sticky; set on an ack with zero outstanding; cleared by accepted start or rst
- cmd_valid  out  1  command present
- cmd_ready  in  1  PE accepts the command
- cmd_mode  out  1  0 = vectoring, 1 = rotation
- cmd_row_hi  out  ROW_W  upper row of the pair (i-1)
- cmd_row_lo  out  ROW_W  lower row of the pair (i), the row being zeroed
- cmd_col  out  COL_W  column operated on
- cmd_last  out  1  marks the final command of the current pair
- pe_ack  in  1  one pulse per completed command, in issue order

Behaviour:
- Reset values: busy=0, done=0, err=0, cmd_valid=0, cmd_mode/rows/col/last=0. FSM enters IDLE; outstanding=0.
- Transfer occurs when cmd_valid && cmd_ready. While cmd_valid=1 and cmd_ready=0, all cmd_* fields hold stable. cmd_valid never drops without a transfer, except on rst.
- Outstanding counter (0..MAX_OUT):
  - +1 on transfer, -1 on pe_ack; both in the same cycle leaves it unchanged.
  - cmd_valid is asserted only when outstanding < MAX_OUT, or when a pe_ack arrives in the same cycle.
- FSM states: IDLE, VEC, WAIT_VEC, ROT, DRAIN, DONE.
  - IDLE: on start, set j=0, i=ROWS-1, clear err, go to VEC. The command appears the next cycle. start while busy is ignored.
  - VEC: cmd_valid=1, mode=0, row_hi=i-1, row_lo=i, col=j, cmd_last=(j==COLS-1). On transfer, go to WAIT_VEC.
  - WAIT_VEC: wait until outstanding reaches 0 (the angle is available). Go to ROT if j<COLS-1, else go to the advance step.
  - ROT: issue mode=1 for col=j+1..COLS-1 back-to-back, subject to the credit rule. cmd_last=1 on col COLS-1. After the last transfer, go to DRAIN.
  - DRAIN: when outstanding==0, advance:
    - if i > j+1, then i--;
    - else j++ and i=ROWS-1.
    - If j has passed COLS-1, go to DONE; else go to VEC.
  - DONE: done=1 for one cycle, busy drops the same cycle, return to IDLE.
- Default totals: 22 vectoring + 38 rotation = 60 commands.
  - Column 0: 7 pairs x 4 ops; column 1: 6 x 3; column 2: 5 x 2; column 3: 4 x 1.
- pe_ack with outstanding==0: counter stays 0, err=1, sequencing continues.
- rst mid-operation: next edge returns to IDLE, cmd_valid=0, outstanding=0. Late pe_ack pulses after reset set err.
- Counters saturate by construction; no wrap of i below j+1.

Decomposition:
- Package qr_cordic_pkg holds:
  - ROWS/COLS defaults,
  - the cmd_mode constants (MODE_VEC=0, MODE_ROT=1),
  - the FSM state enum,
  - the 13-bit entry width constant shared with QR_CORDIC.
- One sub-module: qr_credit_cnt, the outstanding counter with inc/dec/limit and an underflow flag that feeds err.

Test Plan:
1. cmd_ready=1, pe_ack 3 cycles after each transfer.
   - Start at cycle 0 gives cmd_valid at cycle 1 with (vec,6,7,0).
   - After its ack: (rot,6,7,1), (rot,6,7,2), (rot,6,7,3, last).
   - Totals: 60 transfers, 22 with mode=0, exactly one done pulse, err=0.
2. Random cmd_ready backpressure (~50%).
   - cmd_* fields stay stable whenever valid && !ready.
   - The command sequence is identical to scenario 1.
3. MAX_OUT=2, PE acks delayed 10 cycles.
   - Never more than 2 unacked commands.
   - No VEC issued while outstanding != 0.
4. pe_ack in the same cycle as a transfer with outstanding=1: outstanding stays 1, no extra or missed command.
5. rst asserted after the 20th transfer.
   - Next cycle: busy=0, cmd_valid=0.
   - A following start restarts at (vec,6,7,0).
6. Extra pe_ack while idle sets err=1. The next start clears err and the run completes normally.
